// File: rtl/counter.sv
// Toll-lane vehicle counter: total passes and hipass-equipped passes,
// both registered, wrapping modulo 2^WIDTH, with synchronous active-low reset.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] hipass_in
);

    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] hipass_nxt;

    // Modulo increment; the carry out is deliberately discarded.
    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] val);
        logic [WIDTH:0] sum;
        sum = {1'b0, val} + {{WIDTH{1'b0}}, 1'b1};
        return sum[WIDTH-1:0];
    endfunction

    always_comb begin
        count_nxt  = count;
        hipass_nxt = hipass_in;
        unique case (en)
            2'b10: count_nxt = wrap_inc(count);
            2'b11: begin
                count_nxt  = wrap_inc(count);
                hipass_nxt = wrap_inc(hipass_in);
            end
            // 2'b01 carries a hipass flag without a pass event: ignored.
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            hipass_in <= '0;
        end else begin
            count     <= count_nxt;
            hipass_in <= hipass_nxt;
        end
    end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: expected values are queued as each edge's
// stimulus is driven and compared just after that edge.
module tb_counter;

    localparam int W = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   en;
    logic [W-1:0] count;
    logic [W-1:0] hipass_in;

    typedef struct {
        string tag;
        int    c;
        int    h;
    } exp_t;

    exp_t sb[$];
    int   m_c = 0;
    int   m_h = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .count     (count),
        .hipass_in (hipass_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one edge's inputs, predict the result, then compare after the edge.
    // With glitch set, en pulses to 2'b11 mid-cycle before settling on e.
    task automatic step(input string tag, input logic r, input logic [1:0] e,
                        input bit glitch = 1'b0);
        exp_t x;
        if (glitch) begin
            en = 2'b11;
            #2;
        end
        rst_n = r;
        en    = e;
        if (!r) begin
            m_c = 0;
            m_h = 0;
        end else if (e == 2'b10) begin
            m_c = (m_c + 1) % MOD;
        end else if (e == 2'b11) begin
            m_c = (m_c + 1) % MOD;
            m_h = (m_h + 1) % MOD;
        end
        sb.push_back('{tag, m_c, m_h});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.tag, ".count"}, int'(count), x.c);
        chk({x.tag, ".hipass"}, int'(hipass_in), x.h);
    endtask

    task automatic run(input string tag, input logic [1:0] e, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, e);
    endtask

    task automatic do_reset();
        step("rst", 1'b0, 2'b11);
        step("rst", 1'b0, 2'b11);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 2'b11;
        @(negedge clk);

        // Reset with en active for two edges
        do_reset();
        chk("reset.count", int'(count), 0);
        chk("reset.hipass", int'(hipass_in), 0);

        // Releasing reset between edges must not disturb the outputs
        #2 rst_n = 1'b1;
        #1;
        chk("rst_release.count", int'(count), 0);

        // Plain run then idle
        run("plain", 2'b10, 7);
        chk("plain7.count", int'(count), 7);
        chk("plain7.hipass", int'(hipass_in), 0);
        run("idle", 2'b00, 3);
        chk("idle.count", int'(count), 7);

        // Mid-cycle en glitch settling to idle has no effect
        step("glitch", 1'b1, 2'b00, 1'b1);
        chk("glitch.count", int'(count), 7);

        // Mixed traffic
        do_reset();
        run("hip", 2'b11, 3);
        chk("mix3.count", int'(count), 3);
        chk("mix3.hipass", int'(hipass_in), 3);
        run("plain", 2'b10, 2);
        chk("mix5.count", int'(count), 5);
        chk("mix5.hipass", int'(hipass_in), 3);
        run("invalid", 2'b01, 4);
        chk("inv.count", int'(count), 5);
        chk("inv.hipass", int'(hipass_in), 3);

        // Joint wrap
        do_reset();
        run("wrap", 2'b11, 15);
        chk("wrap15.count", int'(count), 15);
        chk("wrap15.hipass", int'(hipass_in), 15);
        step("wrap", 1'b1, 2'b11);
        chk("wrap0.count", int'(count), 0);
        chk("wrap0.hipass", int'(hipass_in), 0);

        // Independent wrap: count 15, hipass 2
        do_reset();
        run("ind", 2'b11, 2);
        run("ind", 2'b10, 13);
        chk("ind_pre.count", int'(count), 15);
        chk("ind_pre.hipass", int'(hipass_in), 2);
        step("ind", 1'b1, 2'b10);
        chk("ind.count", int'(count), 0);
        chk("ind.hipass", int'(hipass_in), 2);

        // Reset mid-count with en active, then resume
        do_reset();
        run("mid", 2'b10, 6);
        chk("mid6.count", int'(count), 6);
        step("midrst", 1'b0, 2'b10);
        chk("midrst.count", int'(count), 0);
        step("resume", 1'b1, 2'b10);
        chk("resume.count", int'(count), 1);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic [1:0] e;
            logic       r;
            e = 2'($urandom_range(3, 0));
            r = ($urandom_range(19, 0) != 0);
            step("rand", r, e);
        end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of both counter outputs; all values below are stated for WIDTH=4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: en  input  2  event code sampled each rising edge: en[1] = vehicle-pass event, en[0] = vehicle is hipass-equipped.
REQ-005 Port: count  output  WIDTH  total vehicle-pass counter, registered.
REQ-006 Port: hipass_in  output  WIDTH  hipass-equipped vehicle counter, registered.

Function
REQ-007 The block SHALL drive both outputs directly from internal registers; no combinational path from en to count or hipass_in.
REQ-008 The block SHALL decode en each rising edge while rst_n=1 as follows:
- 2'b00: idle; count and hipass_in hold.
- 2'b10: plain vehicle; count+1; hipass_in holds.
- 2'b11: hipass vehicle; count+1 and hipass_in+1 on the same edge.
- 2'b01: invalid (hipass flag without pass event); both hold, no side effects.
REQ-009 Latency SHALL be one cycle: an update caused by en sampled at edge N is visible immediately after edge N and stable until edge N+1.
REQ-010 The block SHALL count one event per clock edge while en stays asserted; en is level-sampled, not edge-detected.
REQ-011 Increments SHALL be modulo 2^WIDTH: count 15 -> 0 and hipass_in 15 -> 0 on the next qualifying edge, with no saturation and no overflow flag.
REQ-012 Each counter SHALL wrap independently; count wrapping SHALL NOT affect hipass_in, and vice versa.
REQ-013 The invariant hipass_in <= count SHALL hold modulo 2^WIDTH only; no clamping or cross-checking is performed.
REQ-014 en changes between edges SHALL have no effect; only the value present at the rising edge matters.

Reset
REQ-015 When rst_n=0 at a rising edge, the block SHALL set count=0 and hipass_in=0 after that edge, regardless of en.
REQ-016 Reset SHALL have priority over every en code, including when asserted mid-count with en active.
REQ-017 Reset SHALL take effect only at a clock edge; deasserting rst_n between edges SHALL NOT change the outputs.
REQ-018 After rst_n returns to 1, the first en code sampled at the following edge SHALL be acted on normally.
REQ-019 Output values before the first reset edge are undefined; a bench SHALL apply reset before checking any output.

Verification
REQ-020 Reset: rst_n=0 for 2 edges with en=2'b11 -> count=0, hipass_in=0.
REQ-021 Plain run:
- from reset, en=2'b10 for 7 edges -> count=7, hipass_in=0;
- then en=2'b00 for 3 edges -> count holds 7.
REQ-022 Mixed traffic:
- from reset, en=2'b11 for 3 edges -> count=3, hipass_in=3;
- then en=2'b10 for 2 edges -> count=5, hipass_in=3;
- then en=2'b01 for 4 edges -> count=5, hipass_in=3 (no change).
REQ-023 Wrap: from reset, en=2'b11 for 15 edges -> count=15, hipass_in=15; one more edge -> count=0, hipass_in=0.
REQ-024 Independent wrap: count=15, hipass_in=2, en=2'b10 for one edge -> count=0, hipass_in=2.
REQ-025 Reset mid-operation: count=6 with en=2'b10, rst_n=0 for one edge -> count=0; rst_n=1 with en=2'b10 on the next edge -> count=1.
